// File: rtl/dlfloat_result_serializer.sv
// Buffers 16-bit DLFloat16 MAC results in a small FIFO and streams each one as a
// byte frame (low, high[, checksum]). Define SER_CHECKSUM_EN to append a XOR checksum byte.
module dlfloat_result_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        res_in,
    input  logic               res_valid,
    output logic [7:0]         out_byte,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               ovf_sticky,
    input  logic               clr_ovf,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
`ifdef SER_CHECKSUM_EN
    localparam logic [1:0] S_CHK  = 2'd3;
`endif

    logic [15:0]        r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;
    logic [1:0]         r_state;
    logic [15:0]        r_hold;
    logic [7:0]         r_out_byte;
    logic               r_out_valid;

    logic               w_hs;
    logic               w_full;
    logic               w_not_empty;
    logic               w_push;
    logic               w_drop;
    logic               w_frame_end;
    logic               w_pop;
    logic [15:0]        w_pop_data;

    // A byte transfers on a rising edge where out_valid and out_ready are both high;
    // out_valid is a register and never looks at out_ready combinationally.
    assign w_hs        = r_out_valid & out_ready;
    assign w_full      = (r_count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign w_not_empty = (r_count != '0);
    assign w_push      = res_valid & ~w_full;
    assign w_drop      = res_valid & w_full;
`ifdef SER_CHECKSUM_EN
    assign w_frame_end = w_hs & (r_state == S_CHK);
`else
    assign w_frame_end = w_hs & (r_state == S_HI);
`endif
    assign w_pop       = w_not_empty & ((r_state == S_IDLE) | w_frame_end);
    assign w_pop_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= res_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hold      <= 16'h0000;
            r_out_byte  <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_hold      <= w_pop_data;
                        r_out_byte  <= w_pop_data[7:0];
                        r_out_valid <= 1'b1;
                        r_state     <= S_LO;
                    end
                end
                S_LO: begin
                    if (w_hs) begin
                        r_out_byte <= r_hold[15:8];
                        r_state    <= S_HI;
                    end
                end
`ifdef SER_CHECKSUM_EN
                S_HI: begin
                    if (w_hs) begin
                        r_out_byte <= r_hold[7:0] ^ r_hold[15:8];
                        r_state    <= S_CHK;
                    end
                end
                S_CHK: begin
`else
                S_HI: begin
`endif
                    // End of frame: chain straight into the next result if one is waiting.
                    if (w_hs) begin
                        if (w_pop) begin
                            r_hold     <= w_pop_data;
                            r_out_byte <= w_pop_data[7:0];
                            r_state    <= S_LO;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign out_byte   = r_out_byte;
    assign out_valid  = r_out_valid;
    assign fifo_count = r_count;
    assign ovf_sticky = r_ovf;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_dlfloat_result_serializer.sv
// Self-checking bench for dlfloat_result_serializer: byte scoreboard fed at push time,
// consumed by a handshake monitor; directed scenarios followed by a random-ready phase.
module tb_dlfloat_result_serializer;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_AW    = 2;
`ifdef SER_CHECKSUM_EN
    localparam int FRAME = 3;
`else
    localparam int FRAME = 2;
`endif

    logic               clk;
    logic               rst;
    logic [15:0]        res_in;
    logic               res_valid;
    logic [7:0]         out_byte;
    logic               out_valid;
    logic               out_ready;
    logic [FIFO_AW:0]   fifo_count;
    logic               ovf_sticky;
    logic               clr_ovf;
    logic [1:0]         dbg_state;

    int                 n_tests = 0;
    int                 n_fail  = 0;
    logic [7:0]         exp_q[$];

    dlfloat_result_serializer #(.FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .res_in     (res_in),
        .res_valid  (res_valid),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .ovf_sticky (ovf_sticky),
        .clr_ovf    (clr_ovf),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the bytes a result should produce; call when it is known to be accepted.
    task automatic expect_result(input logic [15:0] v);
        exp_q.push_back(v[7:0]);
        exp_q.push_back(v[15:8]);
`ifdef SER_CHECKSUM_EN
        exp_q.push_back(v[7:0] ^ v[15:8]);
`endif
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain_timeout", 32'(exp_q.size()), 0);
        tick();
    endtask

    // Values at the falling edge are what the next rising edge will see.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_byte", 32'(exp_q.size()), 1);
            end else begin
                check_eq("byte", out_byte, exp_q.pop_front());
            end
        end
    end

    initial begin
        int sent;
        int cyc;
        rst       = 1'b1;
        res_in    = 16'h0000;
        res_valid = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        repeat (3) tick();
        check_eq("rst_out_byte", out_byte, 8'h00);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_fifo_count", fifo_count, 0);
        check_eq("rst_ovf", ovf_sticky, 0);
        check_eq("rst_state", dbg_state, 0);
        rst = 1'b0;
        tick();

        // 1: single result, latency and frame length
        out_ready = 1'b1;
        res_in = 16'h3E00; res_valid = 1'b1; expect_result(16'h3E00);
        tick();
        res_valid = 1'b0;
        check_eq("t1_valid_t0", out_valid, 0);
        tick();
        check_eq("t1_valid_lo", out_valid, 1);
        check_eq("t1_byte_lo", out_byte, 8'h00);
        tick();
        check_eq("t1_valid_hi", out_valid, 1);
        check_eq("t1_byte_hi", out_byte, 8'h3E);
`ifdef SER_CHECKSUM_EN
        tick();
        check_eq("t1_valid_chk", out_valid, 1);
        check_eq("t1_byte_chk", out_byte, 8'h3E);
`endif
        tick();
        check_eq("t1_valid_end", out_valid, 0);

        // 2: back-to-back results with no bubble
        tick();
        res_in = 16'h1234; res_valid = 1'b1; expect_result(16'h1234);
        tick();
        res_in = 16'hABCD; expect_result(16'hABCD);
        tick();
        res_valid = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            check_eq("t2_no_bubble", out_valid, 1);
            tick();
        end
        check_eq("t2_valid_end", out_valid, 0);

        // 3: stall holds the low byte
        out_ready = 1'b0;
        tick();
        res_in = 16'hBEEF; res_valid = 1'b1; expect_result(16'hBEEF);
        tick();
        res_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_stall_valid", out_valid, 1);
            check_eq("t3_stall_byte", out_byte, 8'hEF);
            tick();
        end
        out_ready = 1'b1;
        wait_drain(20);

        // 4: overflow with the consumer stalled
        out_ready = 1'b0;
        tick();
        res_in = 16'hA000; res_valid = 1'b1; expect_result(16'hA000);
        tick();
        res_valid = 1'b0;
        tick();
        check_eq("t4_count_after_hold", fifo_count, 0);
        for (int i = 1; i <= 5; i++) begin
            res_in = 16'hA000 + 16'(i); res_valid = 1'b1;
            if (i <= FIFO_DEPTH) expect_result(16'hA000 + 16'(i));
            tick();
        end
        res_valid = 1'b0;
        check_eq("t4_count_full", fifo_count, FIFO_DEPTH);
        check_eq("t4_ovf_set", ovf_sticky, 1);
        res_in = 16'hA006; res_valid = 1'b1; clr_ovf = 1'b1;
        tick();
        res_valid = 1'b0;
        check_eq("t4_ovf_set_wins", ovf_sticky, 1);
        tick();
        clr_ovf = 1'b0;
        check_eq("t4_ovf_cleared", ovf_sticky, 0);
        check_eq("t4_count_kept", fifo_count, FIFO_DEPTH);
        out_ready = 1'b1;
        wait_drain(60);
        check_eq("t4_count_empty", fifo_count, 0);

        // 5: reset in the middle of a frame
        tick();
        res_in = 16'h5A5A; res_valid = 1'b1; expect_result(16'h5A5A);
        tick();
        res_in = 16'h1111;
        tick();
        res_valid = 1'b0;
        tick();
        check_eq("t5_at_hi", dbg_state, 2);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_valid", out_valid, 0);
        check_eq("t5_rst_count", fifo_count, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t5_silent", out_valid, 0);
        end

        // 6: special values / checksum frame
        res_in = 16'hF00F; res_valid = 1'b1; expect_result(16'hF00F);
        tick();
        res_in = 16'hFFFF; expect_result(16'hFFFF);
        tick();
        res_in = 16'h7DFE; expect_result(16'h7DFE);
        tick();
        res_in = 16'h0000; expect_result(16'h0000);
        tick();
        res_valid = 1'b0;
        wait_drain(40);
        check_eq("t6_idle", out_valid, 0);

        // 7: random consumer back-pressure
        sent = 0;
        cyc  = 0;
        while (sent < 12 && cyc < 2000) begin
            tick();
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            res_valid = 1'b0;
            if (exp_q.size() <= FRAME && $urandom_range(0, 1) == 1) begin
                res_in = 16'($urandom_range(0, 65535));
                res_valid = 1'b1;
                expect_result(res_in);
                sent++;
            end
        end
        check_eq("t7_sent", sent, 12);
        tick();
        res_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain(100);
        check_eq("t7_count_empty", fifo_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
